ramdisk_arbiter: RTL and testbench

- Shares the single command/data port of the SDRAM RAM disk between NREQ disk-controller front ends (e.g. RK and RL emulations).
- Round-robin selects one pending block request, issues it as a level command, and tracks completion through the RAM disk's command_ready.
- Steers the 16-bit word FIFO strobes to the granted requester only.
- Sits between the controllers and the RAM disk, in the RAM disk's clock domain.

---
 rtl/ramdisk_arbiter_if.sv | 63 ++++++
 rtl/ramdisk_arbiter.sv | 152 +++++++++++++++
 tb/tb_ramdisk_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ramdisk_arbiter_if.sv
// Requester and RAM-disk signal bundle for ramdisk_arbiter.
// slave = arbiter side, master = controllers plus RAM disk.
interface ramdisk_arbiter_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_write;
   logic [32*NREQ-1:0]   req_addr;
   logic [NREQ-1:0]      req_grant;
   logic [NREQ-1:0]      req_done;
   logic [16*NREQ-1:0]   req_write_data;
   logic [NREQ-1:0]      req_write_data_enable;
   logic [15:0]          req_read_data;
   logic [NREQ-1:0]      req_read_data_enable;
   logic                 ram_command_ready;
   logic                 ram_read_cmd;
   logic                 ram_write_cmd;
   logic [31:0]          ram_block_address;
   logic [15:0]          ram_write_data;
   logic                 ram_write_data_enable;
   logic [15:0]          ram_read_data;
   logic                 ram_read_data_enable;

   modport slave (
      input  req_valid,
      input  req_write,
      input  req_addr,
      input  req_write_data,
      input  ram_command_ready,
      input  ram_write_data_enable,
      input  ram_read_data,
      input  ram_read_data_enable,
      output req_grant,
      output req_done,
      output req_write_data_enable,
      output req_read_data,
      output req_read_data_enable,
      output ram_read_cmd,
      output ram_write_cmd,
      output ram_block_address,
      output ram_write_data
   );

   modport master (
      output req_valid,
      output req_write,
      output req_addr,
      output req_write_data,
      output ram_command_ready,
      output ram_write_data_enable,
      output ram_read_data,
      output ram_read_data_enable,
      input  req_grant,
      input  req_done,
      input  req_write_data_enable,
      input  req_read_data,
      input  req_read_data_enable,
      input  ram_read_cmd,
      input  ram_write_cmd,
      input  ram_block_address,
      input  ram_write_data
   );
endinterface

// File: rtl/ramdisk_arbiter.sv
// Round-robin arbiter sharing the SDRAM RAM-disk command/data
// port between NREQ disk-controller front ends.
module ramdisk_arbiter #(
   parameter int NREQ    = 2,
   parameter int HOLDOFF = 3
) (
   input  logic             ui_clk,
   input  logic             reset_n,
   ramdisk_arbiter_if.slave bus
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(HOLDOFF + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      BUSY,
      HOLD
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [IW-1:0]   rr;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   sel;
   logic            sel_hit;
   logic [IW:0]     scan;
   logic [31:0]     sel_addr;
   logic            sel_wr;
   logic            wr;
   logic [NREQ-1:0] grant;
   logic [NREQ-1:0] done;
   logic [31:0]     addr;
   logic [CW-1:0]   cnt;
   logic [15:0]     wdata;

   // Walk backwards so the index closest to rr is the last one kept.
   always_comb begin
      sel     = rr;
      sel_hit = 1'b0;
      scan    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         scan = {1'b0, rr} + (IW+1)'(k);
         if (scan >= (IW+1)'(NREQ))
            scan = scan - (IW+1)'(NREQ);
         if (bus.req_valid[scan[IW-1:0]]) begin
            sel     = scan[IW-1:0];
            sel_hit = 1'b1;
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_wr   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (sel == IW'(i)) begin
            sel_addr = bus.req_addr[32*i +: 32];
            sel_wr   = bus.req_write[i];
         end
      end
   end

   always_comb begin
      wdata = '0;
      for (int i = 0; i < NREQ; i++)
         if (grant[i])
            wdata = bus.req_write_data[16*i +: 16];
   end

   always_ff @(posedge ui_clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:
            if (bus.ram_command_ready && sel_hit)
               state_nx = ISSUE;
         ISSUE:
            if (!bus.ram_command_ready)
               state_nx = BUSY;
         BUSY:
            if (bus.ram_command_ready)
               state_nx = HOLD;
         HOLD:
            if (cnt == CW'(HOLDOFF - 1))
               state_nx = IDLE;
         default:
            state_nx = IDLE;
      endcase
   end

   // Request fields are captured once at selection and held
   // until the next IDLE, regardless of what the requester does.
   always_ff @(posedge ui_clk or negedge reset_n) begin
      if (!reset_n) begin
         rr    <= '0;
         idx   <= '0;
         addr  <= '0;
         wr    <= 1'b0;
         grant <= '0;
         done  <= '0;
         cnt   <= '0;
      end else begin
         done <= '0;
         if (state == IDLE && state_nx == ISSUE) begin
            idx   <= sel;
            addr  <= sel_addr;
            wr    <= sel_wr;
            grant <= NREQ'(1) << sel;
         end
         if (state == BUSY && state_nx == HOLD) begin
            done  <= grant;
            grant <= '0;
            rr    <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
         end
         if (state == HOLD)
            cnt <= cnt + 1'b1;
         else
            cnt <= '0;
      end
   end

   always_comb begin
      bus.ram_read_cmd  = 1'b0;
      bus.ram_write_cmd = 1'b0;
      if (state == ISSUE) begin
         if (wr)
            bus.ram_write_cmd = 1'b1;
         else
            bus.ram_read_cmd  = 1'b1;
      end
   end

   assign bus.req_grant         = grant;
   assign bus.req_done          = done;
   assign bus.ram_block_address = addr;
   assign bus.ram_write_data    = wdata;
   assign bus.req_read_data     = bus.ram_read_data;

   assign bus.req_write_data_enable =
      {NREQ{bus.ram_write_data_enable}} & grant;
   assign bus.req_read_data_enable =
      {NREQ{bus.ram_read_data_enable}} & grant;

endmodule

// File: tb/tb_ramdisk_arbiter.sv
// Directed and random bench for ramdisk_arbiter with a RAM-disk
// model and a round-robin reference kept in plain arithmetic.
module tb_ramdisk_arbiter;

   localparam int NREQ    = 2;
   localparam int HOLDOFF = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   ramdisk_arbiter_if #(.NREQ(NREQ)) bus ();

   ramdisk_arbiter #(
      .NREQ    (NREQ),
      .HOLDOFF (HOLDOFF)
   ) dut (
      .ui_clk  (clk),
      .reset_n (rst_n),
      .bus     (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   // RAM-disk model state
   int nwords     = 16;
   bit force_busy = 1'b0;
   int mphase     = 0;
   int mcnt       = 0;
   int mdly       = 1;
   int mwords     = 0;
   int last_dly   = 0;
   bit mwr        = 1'b0;

   // monitor state
   int cyc           = 0;
   int cur_exp       = 0;
   int rd_cnt[NREQ];
   int wr_cnt[NREQ];
   int dn_cnt[NREQ];
   int done_total    = 0;
   int last_done_cyc = -1;
   int min_gap       = 1000000;
   int viol          = 0;
   int data_err      = 0;
   int cmd_hi        = 0;
   bit prev_cmd      = 1'b0;
   logic [NREQ-1:0] prev_grant = '0;
   logic [NREQ-1:0] grant_log[$];
   logic [32:0]     cmd_log[$];

   // reference round-robin pointer
   int ptr = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++)
         if (v[(p + k) % NREQ])
            return (p + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int e);
      if (e < 0)
         return '0;
      return NREQ'(1) << e;
   endfunction

   task automatic clear_counts();
      for (int i = 0; i < NREQ; i++) begin
         rd_cnt[i] = 0;
         wr_cnt[i] = 0;
         dn_cnt[i] = 0;
      end
      data_err = 0;
   endtask

   task automatic wait_grant(output logic [NREQ-1:0] g);
      int n = 0;
      while (bus.req_grant == '0 && n < 300) begin
         @(negedge clk); #1;
         n++;
      end
      g = bus.req_grant;
   endtask

   task automatic wait_done(input string tag, input int target);
      int n = 0;
      while (done_total < target && n < 5000) begin
         @(negedge clk); #1;
         n++;
      end
      check(tag, done_total, target);
   endtask

   task automatic wait_busy(input string tag);
      int n = 0;
      while (!(bus.req_grant != '0 && !bus.ram_command_ready)
             && n < 300) begin
         @(negedge clk); #1;
         n++;
      end
      check(tag, n < 300, 1);
   endtask

   function automatic logic [32:0] last_cmd();
      if (cmd_log.size() == 0)
         return 'x;
      return cmd_log[cmd_log.size() - 1];
   endfunction

   // One complete transfer with the given valid pattern.
   task automatic xfer(input string tag, input logic [NREQ-1:0] v,
                       input int nw);
      logic [NREQ-1:0] g;
      logic [32:0]     ec;
      int e;
      int n0;
      int target;
      e       = pick(v, ptr);
      cur_exp = e;
      nwords  = nw;
      ec      = {bus.req_write[e], bus.req_addr[32*e +: 32]};
      n0      = cmd_log.size();
      target  = done_total + 1;
      clear_counts();
      bus.req_valid = v;
      wait_grant(g);
      bus.req_valid = '0;
      check({tag, "_grant"}, g, onehot(e));
      check({tag, "_cmd"}, last_cmd(), ec);
      wait_done({tag, "_done"}, target);
      check({tag, "_ncmd"}, cmd_log.size(), n0 + 1);
      check({tag, "_cmdlen"}, cmd_hi, last_dly + 1);
      for (int i = 0; i < NREQ; i++) begin
         check({tag, "_rd"}, rd_cnt[i],
               (i == e && !ec[32]) ? nw : 0);
         check({tag, "_wr"}, wr_cnt[i],
               (i == e && ec[32]) ? nw : 0);
         check({tag, "_dn"}, dn_cnt[i], (i == e) ? 1 : 0);
      end
      check({tag, "_data"}, data_err, 0);
      ptr = (e + 1) % NREQ;
   endtask

   // RAM disk: accepts a level command, drops command_ready after a
   // random delay, moves nwords words, then raises command_ready.
   initial begin
      bus.ram_command_ready     = 1'b1;
      bus.ram_read_data_enable  = 1'b0;
      bus.ram_write_data_enable = 1'b0;
      bus.ram_read_data         = '0;
      bus.req_write_data        = '0;
      forever begin
         @(posedge clk); #1;
         bus.ram_read_data_enable  = 1'b0;
         bus.ram_write_data_enable = 1'b0;
         for (int i = 0; i < NREQ; i++)
            bus.req_write_data[16*i +: 16] = 16'($urandom);
         if (!rst_n) begin
            mphase = 0;
            bus.ram_command_ready = 1'b1;
         end else if (force_busy && mphase == 0) begin
            bus.ram_command_ready = 1'b0;
         end else begin
            case (mphase)
               0: begin
                  bus.ram_command_ready = 1'b1;
                  if (bus.ram_read_cmd || bus.ram_write_cmd) begin
                     mwr    = bus.ram_write_cmd;
                     mdly   = $urandom_range(1, 5);
                     mcnt   = 0;
                     mphase = 1;
                  end
               end
               1: begin
                  mcnt++;
                  if (mcnt == mdly) begin
                     bus.ram_command_ready = 1'b0;
                     last_dly = mdly;
                     mwords   = 0;
                     mphase   = 2;
                  end
               end
               default: begin
                  if (mwords < nwords) begin
                     if ($urandom_range(0, 3) != 0) begin
                        if (mwr) begin
                           bus.ram_write_data_enable = 1'b1;
                        end else begin
                           bus.ram_read_data_enable = 1'b1;
                           bus.ram_read_data = 16'($urandom);
                        end
                        mwords++;
                     end
                  end else begin
                     bus.ram_command_ready = 1'b1;
                     mphase = 0;
                  end
               end
            endcase
         end
      end
   end

   // monitor: strobe/done counters, command log, gap and data checks
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_read_data_enable[i])  rd_cnt[i]++;
            if (bus.req_write_data_enable[i]) wr_cnt[i]++;
            if (bus.req_done[i])              dn_cnt[i]++;
         end
         if (bus.req_done != '0) begin
            done_total++;
            last_done_cyc = cyc;
         end
         if (bus.ram_read_cmd && bus.ram_write_cmd) viol++;
         if ($countones(bus.req_grant) > 1)        viol++;
         if (bus.ram_read_data_enable &&
             bus.req_read_data !== bus.ram_read_data)
            data_err++;
         if (bus.ram_write_data_enable &&
             bus.ram_write_data !== bus.req_write_data[16*cur_exp +: 16])
            data_err++;
         if ((bus.ram_read_cmd || bus.ram_write_cmd) && !prev_cmd) begin
            cmd_log.push_back({bus.ram_write_cmd, bus.ram_block_address});
            cmd_hi = 0;
            if (last_done_cyc >= 0 && cyc - last_done_cyc - 1 < min_gap)
               min_gap = cyc - last_done_cyc - 1;
         end
         if (bus.ram_read_cmd || bus.ram_write_cmd)
            cmd_hi++;
         if (bus.req_grant != '0 && prev_grant == '0)
            grant_log.push_back(bus.req_grant);
         prev_cmd   = bus.ram_read_cmd || bus.ram_write_cmd;
         prev_grant = bus.req_grant;
      end
   end

   initial begin
      logic [NREQ-1:0] g;
      int exp_q[$];
      int g0;
      int target;
      int done_before;
      int ncmd;

      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_addr  = '0;
      clear_counts();

      repeat (3) @(negedge clk);
      #1;
      check("rst_grant", bus.req_grant, 0);
      check("rst_done", bus.req_done, 0);
      check("rst_cmd", {bus.ram_read_cmd, bus.ram_write_cmd}, 0);
      check("rst_addr", bus.ram_block_address, 0);
      check("rst_wdata", bus.ram_write_data, 0);
      rst_n = 1'b1;
      @(negedge clk); #1;

      // single read on requester 0
      bus.req_write[0]     = 1'b0;
      bus.req_addr[31:0]   = 32'h0000_0005;
      xfer("A", 2'b01, 256);

      // single write on requester 1
      bus.req_write[1]     = 1'b1;
      bus.req_addr[63:32]  = 32'h0000_0012;
      xfer("B", 2'b10, 256);

      // both requesters continuously valid
      bus.req_write = NREQ'($urandom);
      nwords = 16;
      g0 = grant_log.size();
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(pick(2'b11, ptr));
         ptr = (exp_q[k] + 1) % NREQ;
      end
      bus.req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         cur_exp = exp_q[k];
         target  = done_total + 1;
         wait_done("C_done", target);
         if (k == 3)
            bus.req_valid = '0;
      end
      check("C_ngrant", grant_log.size() - g0, 4);
      for (int k = 0; k < 4; k++)
         if (g0 + k < grant_log.size())
            check("C_order", grant_log[g0 + k], onehot(exp_q[k]));
      check("C_gap", min_gap >= HOLDOFF, 1);

      // address change during BUSY must not disturb the latch
      bus.req_addr[31:0]  = 32'h0000_0040;
      bus.req_addr[63:32] = 32'h0000_0077;
      bus.req_write = NREQ'($urandom);
      cur_exp = pick(2'b01, ptr);
      target  = done_total + 1;
      bus.req_valid = 2'b01;
      wait_busy("D_busy");
      bus.req_addr[31:0] = 32'h0000_0099;
      bus.req_valid = 2'b11;
      @(negedge clk); #1;
      @(negedge clk); #1;
      check("D_latched", bus.ram_block_address, 32'h40);
      wait_done("D_done0", target);
      ptr = (cur_exp + 1) % NREQ;
      cur_exp = pick(2'b11, ptr);
      target  = done_total + 1;
      wait_grant(g);
      bus.req_valid = '0;
      check("D_grant", g, onehot(cur_exp));
      check("D_addr", last_cmd(),
            {bus.req_write[cur_exp], bus.req_addr[32*cur_exp +: 32]});
      wait_done("D_done1", target);
      ptr = (cur_exp + 1) % NREQ;

      // RAM disk not ready: no grant, no command
      force_busy = 1'b1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      ncmd = cmd_log.size();
      bus.req_valid = 2'b01;
      repeat (20) @(negedge clk);
      #1;
      check("E_nogrant", bus.req_grant, 0);
      check("E_nocmd", cmd_log.size(), ncmd);
      cur_exp = pick(2'b01, ptr);
      target  = done_total + 1;
      force_busy = 1'b0;
      wait_grant(g);
      bus.req_valid = '0;
      check("E_grant", g, onehot(cur_exp));
      wait_done("E_done", target);
      ptr = (cur_exp + 1) % NREQ;

      // reset in the middle of a transfer
      nwords  = 64;
      cur_exp = pick(2'b10, ptr);
      bus.req_valid = 2'b10;
      wait_busy("F_busy");
      done_before = done_total;
      #1;
      rst_n = 1'b0;
      #1;
      check("F_grant", bus.req_grant, 0);
      check("F_cmd", {bus.ram_read_cmd, bus.ram_write_cmd}, 0);
      check("F_addr", bus.ram_block_address, 0);
      check("F_done", bus.req_done, 0);
      bus.req_valid = 2'b11;
      repeat (3) @(negedge clk);
      #1;
      rst_n   = 1'b1;
      ptr     = 0;
      nwords  = 16;
      cur_exp = pick(2'b11, ptr);
      wait_grant(g);
      bus.req_valid = '0;
      check("F_regrant", g, onehot(cur_exp));
      check("F_nodone", done_total, done_before);
      wait_done("F_done2", done_before + 1);
      ptr = (cur_exp + 1) % NREQ;

      // random patterns against the reference pointer
      for (int t = 0; t < 12; t++) begin
         logic [NREQ-1:0] v;
         v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         bus.req_write = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++)
            bus.req_addr[32*i +: 32] = $urandom;
         xfer("G", v, $urandom_range(1, 8));
      end

      check("protocol", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
